// File: rtl/capture_sequencer.sv
// capture_sequencer: capture-side sequencer for the three-channel trace RAM.
// Arms on command, fills a pre-trigger region, writes circularly while
// waiting for the trigger, counts post-trigger samples, then freezes.
// Optional feature macro: CAP_DECIMATE_EN (sample prescaler via `decimator`).
module capture_sequencer #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic          abort,
  input  logic          trig_det,
  input  logic          smpl_vld,
  input  logic [AW-1:0] trig_pos,
  input  logic [3:0]    decimator,
  input  logic          dump_busy,
  output logic          we,
  output logic          cap_en,
  output logic [AW-1:0] cap_addr,
  output logic [AW-1:0] trace_end,
  output logic          armed,
  output logic          capture_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] ZERO = AW'(0);

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] pre_cnt_q, pre_cnt_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic [AW-1:0] tp_q, tp_d;
  logic [AW-1:0] trace_end_q, trace_end_d;
  logic [AW-1:0] cap_addr_q, cap_addr_d;
  logic          cap_en_q, cap_en_d;
  logic          we_q, we_d;
  logic          armed_q, armed_d;
  logic          done_q, done_d;

  logic          capturing_s;
  logic          arm_ok_s;
  logic          accept_s;
  logic [AW-1:0] pre_target_s;

  assign capturing_s  = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
  assign arm_ok_s     = arm && !dump_busy && ((state_q == S_IDLE) || (state_q == S_DONE));
  // Pre-trigger region length: 2^AW - tp, which is just -tp modulo 2^AW.
  assign pre_target_s = ZERO - tp_q;

`ifdef CAP_DECIMATE_EN
  logic [15:0] presc_q, presc_d;
  logic [15:0] mask_s;

  assign mask_s   = (16'd1 << decimator) - 16'd1;
  assign accept_s = smpl_vld && capturing_s && ((presc_q & mask_s) == mask_s);

  // Prescaler next value: restarts with each new capture and on abort.
  always_comb begin
    presc_d = presc_q;
    if (abort || arm_ok_s) begin
      presc_d = 16'd0;
    end else if (smpl_vld && capturing_s) begin
      presc_d = presc_q + 16'd1;
    end else begin
      presc_d = presc_q;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= 16'd0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  logic unused_decimator_s;
  assign unused_decimator_s = ^decimator;
  assign accept_s = smpl_vld && capturing_s;
`endif

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    tp_d        = tp_q;
    trace_end_d = trace_end_q;
    cap_addr_d  = cap_addr_q;
    cap_en_d    = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      if (accept_s) begin
        cap_en_d   = 1'b1;
        cap_addr_d = wptr_q;
        wptr_d     = wptr_q + ONE;
      end else begin
        cap_en_d   = 1'b0;
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm_ok_s) begin
            state_d    = S_PRE;
            wptr_d     = ZERO;
            pre_cnt_d  = ZERO;
            post_cnt_d = ZERO;
            tp_d       = (trig_pos == ZERO) ? ONE : trig_pos;
          end else begin
            state_d = state_q;
          end
        end
        S_PRE: begin
          if (accept_s) begin
            pre_cnt_d = pre_cnt_q + ONE;
            if ((pre_cnt_q + ONE) == pre_target_s) begin
              state_d = S_ARMED;
            end else begin
              state_d = S_PRE;
            end
          end else begin
            state_d = S_PRE;
          end
        end
        S_ARMED: begin
          if (trig_det) begin
            state_d = S_POST;
            // A coincident sample is already the first post-trigger sample.
            if (accept_s) begin
              post_cnt_d = ONE;
              if (tp_q == ONE) begin
                state_d     = S_DONE;
                trace_end_d = wptr_q;
              end else begin
                state_d = S_POST;
              end
            end else begin
              post_cnt_d = ZERO;
            end
          end else begin
            state_d = S_ARMED;
          end
        end
        S_POST: begin
          if (accept_s) begin
            post_cnt_d = post_cnt_q + ONE;
            if ((post_cnt_q + ONE) == tp_q) begin
              state_d     = S_DONE;
              trace_end_d = wptr_q;
            end else begin
              state_d = S_POST;
            end
          end else begin
            state_d = S_POST;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    // we stays high through the final write so it brackets the last cap_en.
    we_d    = (state_d == S_PRE) || (state_d == S_ARMED) || (state_d == S_POST) ||
              (capturing_s && (state_d == S_DONE));
    armed_d = (state_d == S_ARMED);
    done_d  = (state_d == S_DONE);
  end

  // State, counters and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wptr_q      <= ZERO;
      pre_cnt_q   <= ZERO;
      post_cnt_q  <= ZERO;
      tp_q        <= ONE;
      trace_end_q <= ZERO;
      cap_addr_q  <= ZERO;
      cap_en_q    <= 1'b0;
      we_q        <= 1'b0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      tp_q        <= tp_d;
      trace_end_q <= trace_end_d;
      cap_addr_q  <= cap_addr_d;
      cap_en_q    <= cap_en_d;
      we_q        <= we_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
    end
  end

  assign we           = we_q;
  assign cap_en       = cap_en_q;
  assign cap_addr     = cap_addr_q;
  assign trace_end    = trace_end_q;
  assign armed        = armed_q;
  assign capture_done = done_q;

endmodule
